// File: rtl/bin2bcd_disp_writer_if.sv
// Request/result and digit-write bundle between a requester and bin2bcd_disp_writer.
interface bin2bcd_disp_writer_if #(
  parameter int unsigned BIN_W = 27
);

  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic             overflow;
  logic             write;
  logic [2:0]       sel;
  logic [3:0]       num;

  // Requester side: issues start/value, observes status and the digit-write port.
  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  overflow,
    input  write,
    input  sel,
    input  num
  );

  // Converter side.
  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output overflow,
    output write,
    output sel,
    output num
  );

endinterface

// File: rtl/bin2bcd_disp_writer.sv
// Sequential double-dabble converter that writes its 8 BCD digits into a
// multiplexed seven-segment display's digit memory, one digit per cycle.
module bin2bcd_disp_writer #(
  parameter int unsigned BIN_W   = 27,
  parameter int unsigned MAX_VAL = 99_999_999
) (
  input  logic                   clk,
  input  logic                   reset,
  bin2bcd_disp_writer_if.slave   bus
);

  localparam int unsigned NDIG  = 8;
  localparam int unsigned BCD_W = 4 * NDIG;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned DIG_W = 3;

  localparam logic [BIN_W-1:0] MAX_VAL_W = BIN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(BIN_W - 1);
  localparam logic [DIG_W-1:0] LAST_DIG  = DIG_W'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [BIN_W-1:0] shreg_q,    shreg_d;
  logic [BCD_W-1:0] bcd_q,      bcd_d;
  logic [CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [DIG_W-1:0] dig_cnt_q,  dig_cnt_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             overflow_q, overflow_d;
  logic             write_q,    write_d;
  logic [2:0]       sel_q,      sel_d;
  logic [3:0]       num_q,      num_d;

  // Add-3 correction on every nibble >= 5, evaluated on pre-shift values.
  logic [BCD_W-1:0] bcd_adj_c;

  always_comb begin
    bcd_adj_c = bcd_q;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // State register; reset abandons any conversion or write burst in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed-length CONVERT and WRITE phases, one DONE cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (dig_cnt_q == LAST_DIG) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath and output next values; strobes default low, data holds.
  always_comb begin
    shreg_d    = shreg_q;
    bcd_d      = bcd_q;
    bit_cnt_d  = bit_cnt_q;
    dig_cnt_d  = dig_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    write_d    = 1'b0;
    sel_d      = sel_q;
    num_d      = num_q;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          shreg_d    = bus.bin_in;
          bcd_d      = '0;
          bit_cnt_d  = '0;
          dig_cnt_d  = '0;
          overflow_d = (bus.bin_in > MAX_VAL_W);
          busy_d     = 1'b1;
        end
      end
      S_CONVERT: begin
        busy_d    = 1'b1;
        bcd_d     = {bcd_adj_c[BCD_W-2:0], shreg_q[BIN_W-1]};
        shreg_d   = {shreg_q[BIN_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
      S_WRITE: begin
        busy_d    = 1'b1;
        write_d   = 1'b1;
        sel_d     = dig_cnt_q;
        num_d     = overflow_q ? 4'hF : bcd_q[{dig_cnt_q, 2'b00} +: 4];
        dig_cnt_d = dig_cnt_q + DIG_W'(1);
      end
      S_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q    <= '0;
      bcd_q      <= '0;
      bit_cnt_q  <= '0;
      dig_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      write_q    <= 1'b0;
      sel_q      <= '0;
      num_q      <= '0;
    end else begin
      shreg_q    <= shreg_d;
      bcd_q      <= bcd_d;
      bit_cnt_q  <= bit_cnt_d;
      dig_cnt_q  <= dig_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      write_q    <= write_d;
      sel_q      <= sel_d;
      num_q      <= num_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.write    = write_q;
  assign bus.sel      = sel_q;
  assign bus.num      = num_q;

endmodule

// File: tb/tb_bin2bcd_disp_writer.sv
// Randomised and directed bench for bin2bcd_disp_writer against a latency/decimal model.
module tb_bin2bcd_disp_writer;

  localparam int unsigned BIN_W   = 27;
  localparam int unsigned MAX_VAL = 99_999_999;
  localparam int          W_FIRST = BIN_W + 1;
  localparam int          W_LAST  = BIN_W + 8;
  localparam int          P_DONE  = BIN_W + 9;

  logic clk;
  logic reset;

  bin2bcd_disp_writer_if #(.BIN_W(BIN_W)) bus ();

  bin2bcd_disp_writer #(.BIN_W(BIN_W), .MAX_VAL(MAX_VAL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int cap_cycle = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Decimal digit i of v, or F when v is not displayable.
  function automatic logic [3:0] exp_digit(input logic [BIN_W-1:0] v, input int i);
    int unsigned x;
    x = 32'(v);
    if (x > MAX_VAL) return 4'hF;
    for (int k = 0; k < i; k++) x = x / 10;
    return 4'(x % 10);
  endfunction

  // Behavioural model: phase = edges since capture, -1 when idle.
  int               m_phase;
  logic [BIN_W-1:0] m_val;
  logic             m_ovf;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= -1;
      m_val   <= '0;
      m_ovf   <= 1'b0;
    end else if ((m_phase == -1 || m_phase == P_DONE) && bus.start) begin
      m_phase <= 0;
      m_val   <= bus.bin_in;
      m_ovf   <= (32'(bus.bin_in) > MAX_VAL);
    end else if (m_phase == P_DONE) begin
      m_phase <= -1;
    end else if (m_phase >= 0) begin
      m_phase <= m_phase + 1;
    end
  end

  logic [3:0] burst [8];
  int         wr_count = 0;

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (reset) begin
      automatic bit e_busy  = (m_phase >= 0) && (m_phase <= W_LAST);
      automatic bit e_write = (m_phase >= W_FIRST) && (m_phase <= W_LAST);
      automatic bit e_done  = (m_phase == P_DONE);
      check("busy", int'(bus.busy), int'(e_busy));
      check("write", int'(bus.write), int'(e_write));
      check("done", int'(bus.done), int'(e_done));
      check("overflow", int'(bus.overflow), int'(m_ovf));
      if (e_write) begin
        automatic int s = m_phase - W_FIRST;
        check("sel", int'(bus.sel), s);
        check("num", int'(bus.num), int'(exp_digit(m_val, s)));
      end
      if (bus.write) begin
        burst[bus.sel] = bus.num;
        wr_count++;
      end
    end
  end

  task automatic clear_burst();
    for (int i = 0; i < 8; i++) burst[i] = 4'hE;
  endtask

  task automatic start_conv(input logic [BIN_W-1:0] v);
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.bin_in = v;
    @(posedge clk); #1;
    cap_cycle  = cyc;
    bus.start  = 1'b0;
    bus.bin_in = BIN_W'($urandom);
  endtask

  task automatic wait_done(input string name);
    bit found = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.done) begin
        found = 1;
        break;
      end
    end
    if (!found) fail_now(name);
    else check({name, "_latency"}, cyc - cap_cycle, P_DONE);
  endtask

  task automatic check_burst(input string name, input logic [3:0] d [8]);
    for (int i = 0; i < 8; i++) check(name, int'(burst[i]), int'(d[i]));
  endtask

  logic [3:0] lit [8];
  int         wr_before;
  bit         seen;

  initial begin
    bus.start  = 1'b0;
    bus.bin_in = '0;
    reset      = 1'b0;
    clear_burst();
    repeat (2) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_write", int'(bus.write), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_ovf", int'(bus.overflow), 0);
    check("rst_sel", int'(bus.sel), 0);
    check("rst_num", int'(bus.num), 0);
    #1 reset = 1'b1;

    // Basic conversion, pinned by hand-computed digits.
    start_conv(27'd12_345_678);
    wait_done("basic");
    lit = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    check_burst("basic_digits", lit);

    clear_burst();
    start_conv(27'd0);
    wait_done("zero");
    lit = '{default: 4'd0};
    check_burst("zero_digits", lit);

    clear_burst();
    start_conv(27'd99_999_999);
    wait_done("max");
    lit = '{default: 4'd9};
    check_burst("max_digits", lit);

    clear_burst();
    start_conv(27'd10);
    wait_done("ten");
    lit = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    check_burst("ten_digits", lit);

    clear_burst();
    start_conv(27'd100_000_000);
    @(negedge clk);
    check("ovf_early", int'(bus.overflow), 1);
    wait_done("ovf");
    lit = '{default: 4'hF};
    check_burst("ovf_digits", lit);

    // Random values, occasionally above the displayable range.
    for (int n = 0; n < 14; n++) begin
      logic [BIN_W-1:0] v;
      if ($urandom_range(0, 4) == 0) v = BIN_W'($urandom_range(134_217_727, 100_000_000));
      else v = BIN_W'($urandom_range(99_999_999, 0));
      start_conv(v);
      wait_done("rand");
    end

    // Start during a conversion must be ignored.
    clear_burst();
    wr_before = wr_count;
    start_conv(27'd42);
    repeat (9) @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.bin_in = 27'd5;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    wait_done("ignore");
    lit = '{4'd2, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    check_burst("ignore_digits", lit);
    repeat (45) @(negedge clk);
    check("ignore_writes", wr_count - wr_before, 8);

    // Back-to-back with start held high.
    wr_before = wr_count;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.bin_in = 27'd7;
    @(posedge clk); #1;
    cap_cycle  = cyc;
    bus.bin_in = 27'd300;
    wait_done("b2b_first");
    clear_burst();
    @(posedge clk); #1;
    cap_cycle  = cyc;
    check("b2b_busy", int'(bus.busy), 1);
    bus.start  = 1'b0;
    wait_done("b2b_second");
    lit = '{4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    check_burst("b2b_digits", lit);
    repeat (3) @(negedge clk);
    check("b2b_writes", wr_count - wr_before, 16);

    // Asynchronous reset in the middle of a write burst.
    start_conv(27'd87_654_321);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.write && bus.sel == 3'd3) begin
        seen = 1;
        break;
      end
    end
    if (!seen) fail_now("midrst_wait");
    #1 reset = 1'b0;
    #1;
    check("midrst_write", int'(bus.write), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_sel", int'(bus.sel), 0);
    check("midrst_num", int'(bus.num), 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    wr_before = wr_count;
    repeat (50) @(negedge clk);
    check("midrst_quiet", wr_count - wr_before, 0);
    check("midrst_idle_busy", int'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
